storage_ctrl_unit: RTL and testbench
====================================

Name: storage_ctrl_unit

Overview:
- Parametrised successor to the mode/opcode controller.
- Decodes chip_en/mode/read/write and also owns the storage: one configurable DEPTH x DATA_W array operated as a single-entry BUFFER, a circular FIFO or a LIFO stack.
- Provides status flags, an occupancy count, error pulses and a registered opcode for the datapath and debug logic.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 8, number of storage entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- chip_en  input  2  01 BUFFER, 10 FIFO, 11 LIFO, 00 disabled.
- mode  input  2  same encoding; the unit is active only when mode equals chip_en and is non-zero.
- write  input  1  write request, sampled on each clk edge.
- read  input  1  read request, sampled on each clk edge.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- data_valid  output  1  one-cycle pulse, data_out updated.
- full  output  1  occupancy == DEPTH; in BUFFER mode, occupancy == 1.
- empty  output  1  occupancy == 0.
- count  output  CNT_W  current occupancy.
- overflow  output  1  one-cycle pulse, write rejected.
- underflow  output  1  one-cycle pulse, read rejected.
- opcode  output  4  registered operation code for the cycle just executed.

Behaviour:
- Reset (reset low, asynchronous): pointers and count are 0; data_out is 0.
  - data_valid, overflow and underflow are 0.
  - full=0, empty=1, opcode=4'b00_00, cur_mode=IDLE.
  - Array contents are not reset.
- Reset asserted mid-operation aborts any operation immediately.
- Release is synchronous to clk; the first operation is accepted on the first rising edge with reset high.
- Active mode: sel = (chip_en == mode && chip_en != 00) ? chip_en : IDLE.
  - cur_mode is a register that takes sel each cycle.
- Mode change: if sel != cur_mode, the cycle is a flush cycle.
  - Pointers and count are cleared; read and write are ignored with no error pulses; opcode = {sel, 2'b00}.
  - Normal operation resumes the next cycle.
- IDLE: all requests are ignored; opcode = 00_00.
- Opcode encoding:
  - Upper two bits are the mode.
  - Lower two bits: 00 none or blocked, 01 write, 10 read, 11 simultaneous read and write.
  - opcode is updated on every clock edge.
- BUFFER (entry 0 only):
  - Write stores data_in and sets count=1. A write while full overwrites; this is not an overflow.
  - Read while count=1 outputs the entry and clears count=0.
  - Read while empty raises underflow.
  - Read and write together: data_out takes the old entry, the new data is stored, count stays 1, opcode=01_11. If empty: write only, plus underflow.
- FIFO:
  - wr_ptr and rd_ptr wrap modulo DEPTH.
  - Write when not full stores at wr_ptr, increments wr_ptr and count; opcode 10_01.
  - Read when not empty: data_out = mem[rd_ptr], rd_ptr++, count--; opcode 10_10.
  - Read and write together when not empty: both are performed, count is unchanged (this holds even when full); opcode 10_11.
  - Read and write together when empty: write only, plus underflow; opcode 10_01.
- LIFO:
  - Stack pointer sp equals count.
  - Write (push) when not full stores at mem[sp] and increments sp; opcode 11_01.
  - Read (pop) when not empty: data_out = mem[sp-1] and decrements sp; opcode 11_10.
  - Read and write together: blocked, no state change, overflow=underflow=0, opcode 11_00.
- Errors:
  - Write while full (FIFO/LIFO) is ignored: overflow=1 for one cycle, opcode {mode,00}.
  - Read while empty is ignored: underflow=1 for one cycle.
- Read latency: data_out and data_valid are valid one cycle after the accepting edge. data_out holds its value until the next accepted read.
- Flags: full, empty and count are registered and reflect the state after the edge. count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset/idle: hold reset low for 3 cycles, then chip_en=10, mode=01, write=1.
  - Required: empty=1, count=0, opcode=00_00; no storage change.
- FIFO fill/drain (DEPTH=4): chip_en=mode=10; write 0x11, 0x22, 0x33, 0x44.
  - Required: full=1, count=4.
  - A fifth write (0x55) raises overflow for one cycle.
  - Four reads return 0x11, 0x22, 0x33, 0x44, each with data_valid one cycle later; then empty=1.
  - A further read raises underflow.
- FIFO wrap and simultaneous access: with 0xA0, 0xA1 queued, assert read and write with data_in 0xB0 for 4 cycles.
  - Required: outputs 0xA0, 0xA1, 0xB0, 0xB0; count stays 2; opcode=10_11.
- LIFO: chip_en=mode=11; push 0x01, 0x02, 0x03; assert read and write together.
  - Required on the blocked cycle: opcode 11_00, count=3.
  - Three pops then return 0x03, 0x02, 0x01.
- Mode switch flush: FIFO holding 3 entries, then change to LIFO.
  - Required: on the flush cycle count=0, empty=1, opcode=11_00, and the write on that cycle is ignored.
  - The next push is accepted.
- Async reset mid-burst: drop reset between clock edges during FIFO writes.
  - Required: count=0, opcode=00_00 and data_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/storage_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : storage_ctrl_unit
//  Brief    : Mode/opcode controller owning a DEPTH x DATA_W array used as a
//             single-entry buffer, circular FIFO or LIFO stack.
//  Revision : 1.0 - initial release
// ============================================================================
module storage_ctrl_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        chip_en,
    input  logic [1:0]        mode,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    output logic [3:0]        opcode
);

    localparam int             c_PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_BUF  = 2'b01,
        MODE_FIFO = 2'b10,
        MODE_LIFO = 2'b11
    } mode_t;

    mode_t               r_cur_mode;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_overflow;
    logic                r_underflow;
    logic [3:0]          r_opcode;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    mode_t               w_sel;
    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic                w_do_wr;
    logic                w_do_rd;
    logic                w_ovf;
    logic                w_unf;
    logic [1:0]          w_op_lo;
    logic [c_PTR_W-1:0]  w_wr_addr;
    logic [c_PTR_W-1:0]  w_rd_addr;
    logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CNT_W-1:0]    w_sp_dec;

    assign w_full   = (r_cur_mode == MODE_BUF) ? (r_count == c_ONE) : (r_count == c_DEPTH_CNT);
    assign w_empty  = (r_count == '0);
    assign w_sp_dec = r_count - c_ONE;

    always_comb begin
        w_sel        = (chip_en == mode && chip_en != 2'b00) ? mode_t'(chip_en) : MODE_IDLE;
        w_flush      = (w_sel != r_cur_mode);
        w_do_wr      = 1'b0;
        w_do_rd      = 1'b0;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        w_op_lo      = 2'b00;
        w_wr_addr    = '0;
        w_rd_addr    = '0;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;

        if (w_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            case (r_cur_mode)
                MODE_BUF: begin
                    // Writes always land in entry 0; a write while full overwrites.
                    if (read && !w_empty) begin
                        w_do_rd     = 1'b1;
                        w_count_nxt = '0;
                    end else if (read) begin
                        w_unf = 1'b1;
                    end
                    if (write) begin
                        w_do_wr     = 1'b1;
                        w_count_nxt = c_ONE;
                    end
                    w_op_lo = {w_do_rd, w_do_wr};
                end
                MODE_FIFO: begin
                    w_wr_addr = r_wr_ptr;
                    w_rd_addr = r_rd_ptr;
                    if (read && write) begin
                        w_do_wr = 1'b1;
                        if (w_empty) begin
                            w_unf = 1'b1;
                        end else begin
                            w_do_rd = 1'b1;
                        end
                    end else if (write) begin
                        if (w_full) w_ovf = 1'b1;
                        else        w_do_wr = 1'b1;
                    end else if (read) begin
                        if (w_empty) w_unf = 1'b1;
                        else         w_do_rd = 1'b1;
                    end
                    if (w_do_wr) w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(1);
                    if (w_do_rd) w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);
                    if (w_do_wr && !w_do_rd)      w_count_nxt = r_count + c_ONE;
                    else if (w_do_rd && !w_do_wr) w_count_nxt = w_sp_dec;
                    w_op_lo = {w_do_rd, w_do_wr};
                end
                MODE_LIFO: begin
                    // Stack pointer is the occupancy count itself.
                    w_wr_addr = r_count[c_PTR_W-1:0];
                    w_rd_addr = w_sp_dec[c_PTR_W-1:0];
                    if (write && !read) begin
                        if (w_full) begin
                            w_ovf = 1'b1;
                        end else begin
                            w_do_wr     = 1'b1;
                            w_count_nxt = r_count + c_ONE;
                        end
                    end else if (read && !write) begin
                        if (w_empty) begin
                            w_unf = 1'b1;
                        end else begin
                            w_do_rd     = 1'b1;
                            w_count_nxt = w_sp_dec;
                        end
                    end
                    w_op_lo = {w_do_rd, w_do_wr};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_mode   <= MODE_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_opcode     <= 4'b0000;
        end else begin
            r_cur_mode   <= w_sel;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_data_valid <= w_do_rd;
            r_overflow   <= w_ovf;
            r_underflow  <= w_unf;
            r_opcode     <= {w_sel, w_op_lo};
            if (w_do_rd) r_data_out <= r_mem[w_rd_addr];
        end
    end

    // Array is deliberately left out of reset; writes are still blocked while reset is low.
    always_ff @(posedge clk) begin
        if (reset && w_do_wr) r_mem[w_wr_addr] <= data_in;
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign opcode     = r_opcode;

endmodule
`default_nettype wire

// File: tb/tb_storage_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_storage_ctrl_unit
//  Brief    : Directed self-checking bench for storage_ctrl_unit (DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_storage_ctrl_unit;

    localparam int c_DATA_W = 8;
    localparam int c_DEPTH  = 4;
    localparam int c_CNT_W  = 3;

    logic                clk;
    logic                reset;
    logic [1:0]          chip_en;
    logic [1:0]          mode;
    logic                write;
    logic                read;
    logic [c_DATA_W-1:0] data_in;
    logic [c_DATA_W-1:0] data_out;
    logic                data_valid;
    logic                full;
    logic                empty;
    logic [c_CNT_W-1:0]  count;
    logic                overflow;
    logic                underflow;
    logic [3:0]          opcode;

    int n_checks = 0;
    int n_fails  = 0;

    storage_ctrl_unit #(
        .DATA_W (c_DATA_W),
        .DEPTH  (c_DEPTH),
        .CNT_W  (c_CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .chip_en    (chip_en),
        .mode       (mode),
        .write      (write),
        .read       (read),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .opcode     (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input int exp_cnt, input logic exp_empty,
                                input logic exp_full, input logic [3:0] exp_op);
        check_eq({tag, ".count"}, 32'(count), 32'(exp_cnt));
        check_eq({tag, ".empty"}, 32'(empty), 32'(exp_empty));
        check_eq({tag, ".full"},  32'(full),  32'(exp_full));
        check_eq({tag, ".opcode"}, 32'(opcode), 32'(exp_op));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ce, input logic [1:0] md, input logic wr,
                         input logic rd, input logic [7:0] din);
        chip_en = ce;
        mode    = md;
        write   = wr;
        read    = rd;
        data_in = din;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(2'b10, 2'b01, 1'b1, 1'b0, 8'h99);
        repeat (3) tick();

        // Reset state
        check_status("rst", 0, 1'b1, 1'b0, 4'b0000);
        check_eq("rst.data_out", 32'(data_out), 32'h0);
        check_eq("rst.data_valid", 32'(data_valid), 32'h0);
        check_eq("rst.ovf", 32'(overflow), 32'h0);
        check_eq("rst.unf", 32'(underflow), 32'h0);

        // Mismatched chip_en/mode stays idle
        reset = 1'b1;
        tick();
        check_status("idle", 0, 1'b1, 1'b0, 4'b0000);

        // FIFO: flush cycle, then fill
        drive(2'b10, 2'b10, 1'b0, 1'b0, 8'h00);
        tick();
        check_status("fifo_flush", 0, 1'b1, 1'b0, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 2'b10, 1'b1, 1'b0, 8'((i + 1) * 8'h11));
            tick();
            check_status($sformatf("fifo_wr%0d", i), i + 1, 1'b0, (i == 3), 4'b1001);
        end
        drive(2'b10, 2'b10, 1'b1, 1'b0, 8'h55);
        tick();
        check_eq("fifo_ovf", 32'(overflow), 32'h1);
        check_status("fifo_ovf", 4, 1'b0, 1'b1, 4'b1000);

        // Drain
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 2'b10, 1'b0, 1'b1, 8'h00);
            tick();
            check_eq($sformatf("fifo_rd%0d.data", i), 32'(data_out), 32'((i + 1) * 8'h11));
            check_eq($sformatf("fifo_rd%0d.valid", i), 32'(data_valid), 32'h1);
            check_status($sformatf("fifo_rd%0d", i), 3 - i, (i == 3), 1'b0, 4'b1010);
            if (i == 0) check_eq("fifo_ovf_pulse", 32'(overflow), 32'h0);
        end
        tick();
        check_eq("fifo_unf", 32'(underflow), 32'h1);
        check_eq("fifo_unf.valid", 32'(data_valid), 32'h0);
        check_eq("fifo_unf.hold", 32'(data_out), 32'h44);
        check_status("fifo_unf", 0, 1'b1, 1'b0, 4'b1000);

        // Wrap with simultaneous read/write
        drive(2'b10, 2'b10, 1'b1, 1'b0, 8'hA0);
        tick();
        drive(2'b10, 2'b10, 1'b1, 1'b0, 8'hA1);
        tick();
        check_eq("wrap_pre.count", 32'(count), 32'h2);
        begin
            logic [7:0] exp_rw [4];
            exp_rw = '{8'hA0, 8'hA1, 8'hB0, 8'hB0};
            for (int i = 0; i < 4; i++) begin
                drive(2'b10, 2'b10, 1'b1, 1'b1, 8'hB0);
                tick();
                check_eq($sformatf("rw%0d.data", i), 32'(data_out), 32'(exp_rw[i]));
                check_eq($sformatf("rw%0d.valid", i), 32'(data_valid), 32'h1);
                check_status($sformatf("rw%0d", i), 2, 1'b0, 1'b0, 4'b1011);
            end
        end

        // Mode switch flush with three entries queued
        drive(2'b10, 2'b10, 1'b1, 1'b0, 8'hC0);
        tick();
        check_eq("pre_flush.count", 32'(count), 32'h3);
        drive(2'b11, 2'b11, 1'b1, 1'b0, 8'hEE);
        tick();
        check_status("lifo_flush", 0, 1'b1, 1'b0, 4'b1100);
        check_eq("lifo_flush.ovf", 32'(overflow), 32'h0);

        // LIFO push, blocked access, pops
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, 1'b1, 1'b0, 8'(i + 1));
            tick();
            check_status($sformatf("push%0d", i), i + 1, 1'b0, 1'b0, 4'b1101);
        end
        drive(2'b11, 2'b11, 1'b1, 1'b1, 8'h77);
        tick();
        check_status("lifo_block", 3, 1'b0, 1'b0, 4'b1100);
        check_eq("lifo_block.valid", 32'(data_valid), 32'h0);
        check_eq("lifo_block.err", 32'({overflow, underflow}), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, 1'b0, 1'b1, 8'h00);
            tick();
            check_eq($sformatf("pop%0d.data", i), 32'(data_out), 32'(3 - i));
            check_eq($sformatf("pop%0d.valid", i), 32'(data_valid), 32'h1);
            check_status($sformatf("pop%0d", i), 2 - i, (i == 2), 1'b0, 4'b1110);
        end

        // BUFFER mode
        drive(2'b01, 2'b01, 1'b0, 1'b1, 8'h00);
        tick();
        check_status("buf_flush", 0, 1'b1, 1'b0, 4'b0100);
        tick();
        check_eq("buf_unf", 32'(underflow), 32'h1);
        check_status("buf_unf", 0, 1'b1, 1'b0, 4'b0100);
        drive(2'b01, 2'b01, 1'b1, 1'b0, 8'h5A);
        tick();
        check_status("buf_wr", 1, 1'b0, 1'b1, 4'b0101);
        drive(2'b01, 2'b01, 1'b1, 1'b1, 8'h6B);
        tick();
        check_eq("buf_rw.data", 32'(data_out), 32'h5A);
        check_status("buf_rw", 1, 1'b0, 1'b1, 4'b0111);
        drive(2'b01, 2'b01, 1'b0, 1'b1, 8'h00);
        tick();
        check_eq("buf_rd.data", 32'(data_out), 32'h6B);
        check_status("buf_rd", 0, 1'b1, 1'b0, 4'b0110);

        // Async reset mid-burst
        drive(2'b10, 2'b10, 1'b1, 1'b0, 8'h11);
        tick();
        tick();
        drive(2'b10, 2'b10, 1'b1, 1'b1, 8'h22);
        tick();
        check_eq("pre_arst.valid", 32'(data_valid), 32'h1);
        check_eq("pre_arst.count", 32'(count), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check_status("arst", 0, 1'b1, 1'b0, 4'b0000);
        check_eq("arst.valid", 32'(data_valid), 32'h0);
        check_eq("arst.data_out", 32'(data_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
